// File: rtl/buff_input_win_reader.sv
// Read controller for the 25-band input buffer: walks every KxK window position
// (channel innermost) and streams each tap-aligned window to the PE array.
module buff_input_win_reader #(
    parameter int SRAM_DEPTH = 1176,
    parameter int BAND_WIDTH = 25,
    parameter int DATA_WIDTH = 8,
    parameter int IN_W       = 14,
    parameter int IN_H       = 14,
    parameter int IN_CH      = 6,
    parameter int K          = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          enb      [BAND_WIDTH],
    output logic [$clog2(SRAM_DEPTH)-1:0] addrb    [BAND_WIDTH],
    input  logic [DATA_WIDTH-1:0]         dob      [BAND_WIDTH],
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [DATA_WIDTH-1:0]         win_data [BAND_WIDTH],
    output logic                          win_last_ch,
    output logic                          win_last
);

    localparam int AW        = $clog2(SRAM_DEPTH);
    localparam int CALC_W    = AW + 1;
    localparam int OUT_W     = IN_W - K + 1;
    localparam int OUT_H     = IN_H - K + 1;
    localparam int CH_STRIDE = IN_H * IN_W;
    localparam int C_W       = $clog2(IN_CH + 1);
    localparam int X_W       = $clog2(OUT_W + 1);
    localparam int Y_W       = $clog2(OUT_H + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [C_W-1:0]     c_p0;
    logic [X_W-1:0]     ox_p0;
    logic [Y_W-1:0]     oy_p0;
    logic [CALC_W-1:0]  base_p0;
    logic               vld_p1;
    logic               last_ch_p1;
    logic               last_p1;
    logic               issue;
    logic               hs;
    logic               c_end;
    logic               ox_end;
    logic               oy_end;
    logic               frame_end;

    // Stage p0: window position counters and the read issue decision
    assign c_end     = (c_p0 == C_W'(IN_CH - 1));
    assign ox_end    = (ox_p0 == X_W'(OUT_W - 1));
    assign oy_end    = (oy_p0 == Y_W'(OUT_H - 1));
    assign frame_end = c_end && ox_end && oy_end;

    // A new read may go out only when dob is free or is being consumed this cycle
    assign issue = (state == S_RUN) && (!vld_p1 || win_ready);
    assign hs    = vld_p1 && win_ready;

    assign base_p0 = CALC_W'(c_p0) * CALC_W'(CH_STRIDE)
                   + CALC_W'(oy_p0) * CALC_W'(IN_W)
                   + CALC_W'(ox_p0);

    for (genvar i = 0; i < BAND_WIDTH; i++) begin : g_band
        localparam int TAP_OFF = (i / K) * IN_W + (i % K);
        assign enb[i]      = issue;
        assign addrb[i]    = AW'(base_p0 + CALC_W'(TAP_OFF));
        // Stage p1: buffer data returns one cycle after issue and is held while enb=0
        assign win_data[i] = dob[i];
    end

    assign win_valid   = vld_p1;
    assign win_last_ch = last_ch_p1;
    assign win_last    = last_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            vld_p1     <= 1'b0;
            last_ch_p1 <= 1'b0;
            last_p1    <= 1'b0;
            c_p0       <= '0;
            ox_p0      <= '0;
            oy_p0      <= '0;
        end else begin
            done <= 1'b0;

            if (issue) begin
                vld_p1     <= 1'b1;
                last_ch_p1 <= c_end;
                last_p1    <= frame_end;
                if (c_end) begin
                    c_p0 <= '0;
                    if (ox_end) begin
                        ox_p0 <= '0;
                        oy_p0 <= oy_end ? '0 : oy_p0 + Y_W'(1);
                    end else begin
                        ox_p0 <= ox_p0 + X_W'(1);
                    end
                end else begin
                    c_p0 <= c_p0 + C_W'(1);
                end
            end else if (hs) begin
                vld_p1 <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && frame_end) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (hs) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buff_input_win_reader.sv
// Scoreboard bench for buff_input_win_reader: a BRAM model feeds dob, a frame-level
// reference model queues the expected windows and a monitor checks every handshake.
module tb_buff_input_win_reader;

    localparam int SRAM_DEPTH = 1176;
    localparam int BW         = 25;
    localparam int DW         = 8;
    localparam int IN_W       = 14;
    localparam int IN_H       = 14;
    localparam int IN_CH      = 6;
    localparam int K          = 5;
    localparam int OUT_W      = IN_W - K + 1;
    localparam int OUT_H      = IN_H - K + 1;
    localparam int N_WIN      = OUT_W * OUT_H * IN_CH;
    localparam int AW         = $clog2(SRAM_DEPTH);

    typedef struct packed {
        logic [BW-1:0][DW-1:0] px;
        logic                  lc;
        logic                  l;
    } win_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          enb      [BW];
    logic [AW-1:0] addrb    [BW];
    logic [DW-1:0] dob      [BW];
    logic          win_valid;
    logic          win_ready;
    logic [DW-1:0] win_data [BW];
    logic          win_last_ch;
    logic          win_last;

    logic [DW-1:0] mem [SRAM_DEPTH];
    win_t          exp_q [$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int issue_idx = 0;
    int last_hs_cyc = -10;

    always #5 clk = ~clk;

    buff_input_win_reader #(
        .SRAM_DEPTH(SRAM_DEPTH), .BAND_WIDTH(BW), .DATA_WIDTH(DW),
        .IN_W(IN_W), .IN_H(IN_H), .IN_CH(IN_CH), .K(K)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .enb(enb), .addrb(addrb), .dob(dob),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_last_ch(win_last_ch), .win_last(win_last)
    );

    // Buffer model: 25 identical bands, 1-cycle read latency, holds while enb=0
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < BW; i++)
            if (enb[i]) dob[i] <= mem[addrb[i]];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic any_enb();
        logic r = 1'b0;
        for (int i = 0; i < BW; i++) r |= enb[i];
        return r;
    endfunction

    function automatic logic all_enb();
        logic r = 1'b1;
        for (int i = 0; i < BW; i++) r &= enb[i];
        return r;
    endfunction

    // Reference: window (oy,ox,c) tap (ky,kx) is pixel [c][oy+ky][ox+kx] of the feature map
    task automatic build_frame();
        win_t w;
        exp_q.delete();
        for (int oy = 0; oy < OUT_H; oy++)
            for (int ox = 0; ox < OUT_W; ox++)
                for (int c = 0; c < IN_CH; c++) begin
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            w.px[ky*K + kx] = mem[c*IN_H*IN_W + (oy + ky)*IN_W + (ox + kx)];
                    w.lc = (c == IN_CH - 1);
                    w.l  = (oy == OUT_H - 1) && (ox == OUT_W - 1) && (c == IN_CH - 1);
                    exp_q.push_back(w);
                end
    endtask

    // Monitor: handshakes against the scoreboard, stall stability, issue addresses, done timing
    logic          stall_prev = 1'b0;
    win_t          stall_snap;

    always @(negedge clk) begin
        win_t act;
        win_t w;
        for (int i = 0; i < BW; i++) act.px[i] = win_data[i];
        act.lc = win_last_ch;
        act.l  = win_last;
        if (rst) begin
            hs_cnt     = 0;
            issue_idx  = 0;
            stall_prev = 1'b0;
        end else begin
            if (start && !busy) begin
                hs_cnt    = 0;
                issue_idx = 0;
            end
            if (any_enb()) begin
                check("enb_uniform", all_enb(), 1'b1);
                case (issue_idx)
                    0:   begin check("w0_addr0", addrb[0], 0); check("w0_addr24", addrb[24], 60); end
                    1:   check("w1_addr0", addrb[0], 196);
                    6:   check("w6_addr0", addrb[0], 1);
                    60:  check("w60_addr0", addrb[0], 14);
                    599: begin check("wlast_addr24", addrb[24], 1175); check("wlast_addr0", addrb[0], 1115); end
                    default: ;
                endcase
                issue_idx++;
            end
            if (win_valid && !win_ready) begin
                check("stall_enb_low", any_enb(), 1'b0);
                if (stall_prev) check("stall_stable", act, stall_snap);
                stall_snap = act;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", hs_cnt, N_WIN);
                end else begin
                    w = exp_q.pop_front();
                    check("win_data", act.px, w.px);
                    check("win_last_ch", act.lc, w.lc);
                    check("win_last", act.l, w.l);
                    if (w.l) last_hs_cyc = cyc;
                end
                hs_cnt++;
            end
            if (done) check("done_latency", cyc, last_hs_cyc + 1);
        end
    end

    // mode 0: ready held high; 1: 3-cycle drop at window 100; 2: random ready plus a stray start
    task automatic run_frame(input int mode, input int rst_at);
        int  n = 0;
        int  drops = 0;
        int  s_cyc;
        logic seen = 1'b0;
        for (int j = 0; j < SRAM_DEPTH; j++) mem[j] = DW'($urandom);
        build_frame();
        @(posedge clk); #1;
        start = 1'b1;
        win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        check("t1_busy", busy, 1'b1);
        check("t1_enb_all", all_enb(), 1'b1);
        while (n < 5000) begin
            case (mode)
                1: if (hs_cnt == 100 && drops < 3) begin win_ready = 1'b0; drops++; end
                   else win_ready = 1'b1;
                2: win_ready = ($urandom_range(0, 3) != 0);
                default: win_ready = 1'b1;
            endcase
            start = (mode == 2 && n == 50);
            if (rst_at > 0 && hs_cnt >= rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                exp_q.delete();
                check("midrst_busy", busy, 1'b0);
                check("midrst_valid", win_valid, 1'b0);
                check("midrst_done", done, 1'b0);
                check("midrst_enb", any_enb(), 1'b0);
                check("midrst_flags", {win_last, win_last_ch}, 2'b00);
                repeat (5) @(posedge clk);
                #1 check("midrst_quiet", {busy, win_valid, any_enb()}, 3'b000);
                return;
            end
            @(posedge clk); #1;
            n++;
            if (done) begin seen = 1'b1; break; end
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("window_count", hs_cnt, N_WIN);
        check("queue_drained", exp_q.size(), 0);
        if (mode == 0) check("done_cycle", cyc - s_cyc, 601);
        @(posedge clk); #1;
        check("busy_after_done", busy, 1'b0);
        check("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_outputs", {busy, done, win_valid, any_enb()}, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_outputs", {busy, done, win_valid, any_enb()}, 4'b0000);
        end
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(0, 300);
        run_frame(0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
